// File: rtl/fifo_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared definitions for the FIFO port arbiter and any other block that
// shares a FIFO port through the round-robin picker.
//   state_e : arbiter FSM state encoding (IDLE, ENQ, DEQ, SETTLE)
//   op_e    : last completed operation, used to alternate enqueue/dequeue
//   IDX_W   : width of a producer index (up to 8 producers)
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ENQ    = 2'd1,
        S_DEQ    = 2'd2,
        S_SETTLE = 2'd3
    } state_e;

    typedef enum logic {
        OP_ENQ = 1'b0,
        OP_DEQ = 1'b1
    } op_e;

    localparam int IDX_W = 3;

endpackage : fifo_arb_pkg

// File: rtl/fifo_port_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Starting one position after the last
// granted index and wrapping modulo N, returns the first asserted request.
// Ports:
//   req_i   [N]      request vector
//   last_i  [IDX_W]  index granted most recently (search starts at last_i+1)
//   any_o            at least one request is asserted
//   idx_o   [IDX_W]  winning index (holds last_i when nothing is requested)
// -----------------------------------------------------------------------------
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic             any_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path through the loop can leave a value unassigned (no latch).
        any_o = 1'b0;
        idx_o = last_i;
        cand  = last_i;
        // Visit last+1, last+2, ... last+N (the last visit is last itself),
        // keeping only the first hit.
        for (int k = 0; k < N; k++) begin
            cand = (cand == IDX_W'(N - 1)) ? '0 : cand + IDX_W'(1);
            if (!any_o && req_i[cand]) begin
                any_o = 1'b1;
                idx_o = cand;
            end
        end
    end

endmodule : rr_pick

// File: rtl/fifo_port_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_port_arbiter
// Shares one FIFO write port between N_REQ producers and one consumer and
// drives the FIFO control unit's enq/deq/data directly. Producers are served
// round-robin; when both an enqueue and a dequeue are eligible the operation
// opposite to the previous one wins. Every operation is followed by a SETTLE
// cycle so the registered FIFO flags are current before re-arbitration.
// Ports:
//   clk, rst            clock (rising edge), async active-low reset
//   req   [N_REQ]       producer requests, held with data until ack
//   din   [N_REQ*WIDTH] producer data, slice i = din[i*WIDTH +: WIDTH]
//   ack   [N_REQ]       one-cycle pulse when producer i's word is written
//   deq_req / deq_ack   consumer request / one-cycle acknowledge (with deq)
//   fifo_full/empty     registered FIFO status flags
//   enq, deq            single-cycle strobes to the FIFO
//   enq_data [WIDTH]    word presented with enq, held between writes
//   grant_id [3]        last granted producer
//   busy                FSM is not idle
// All outputs come straight from flops; no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module fifo_port_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] din,
    output logic [N_REQ-1:0]       ack,
    input  logic                   deq_req,
    output logic                   deq_ack,
    input  logic                   fifo_full,
    input  logic                   fifo_empty,
    output logic                   enq,
    output logic                   deq,
    output logic [WIDTH-1:0]       enq_data,
    output logic [IDX_W-1:0]       grant_id,
    output logic                   busy
);

    state_e             state_q;
    op_e                last_op_q;
    logic [IDX_W-1:0]   grant_q;
    logic [IDX_W-1:0]   sel_q;
    logic [WIDTH-1:0]   data_q;
    logic               enq_q;
    logic               deq_q;
    logic               deq_ack_q;
    logic [N_REQ-1:0]   ack_q;

    logic               pick_any;
    logic [IDX_W-1:0]   pick_idx;
    logic               enq_ok;
    logic               deq_ok;
    logic               do_enq;
    logic               do_deq;

    rr_pick #(
        .N (N_REQ)
    ) u_pick (
        .req_i  (req),
        .last_i (grant_q),
        .any_o  (pick_any),
        .idx_o  (pick_idx)
    );

    // Eligibility. The illegal full&empty combination disables both sides.
    assign enq_ok = pick_any & ~fifo_full;
    assign deq_ok = deq_req & ~fifo_empty;

    // On a tie, do the opposite of the last completed operation.
    assign do_enq = enq_ok & (~deq_ok | (last_op_q == OP_DEQ));
    assign do_deq = deq_ok & (~enq_ok | (last_op_q == OP_ENQ));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: only control and output flops exist here, so all of them
            // take a reset value; strobes drop the instant rst falls.
            state_q   <= S_IDLE;
            last_op_q <= OP_DEQ;
            grant_q   <= IDX_W'(N_REQ - 1);
            sel_q     <= '0;
            data_q    <= '0;
            enq_q     <= 1'b0;
            deq_q     <= 1'b0;
            deq_ack_q <= 1'b0;
            ack_q     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            case (state_q)
                S_IDLE: begin
                    if (do_enq) begin
                        state_q <= S_ENQ;
                        sel_q   <= pick_idx;
                        data_q  <= din[pick_idx*WIDTH +: WIDTH];
                        enq_q   <= 1'b1;
                        ack_q   <= N_REQ'(1) << pick_idx;
                    end else if (do_deq) begin
                        state_q   <= S_DEQ;
                        deq_q     <= 1'b1;
                        deq_ack_q <= 1'b1;
                    end
                end
                S_ENQ: begin
                    // The write completes regardless of req at this point.
                    state_q   <= S_SETTLE;
                    enq_q     <= 1'b0;
                    ack_q     <= '0;
                    grant_q   <= sel_q;
                    last_op_q <= OP_ENQ;
                end
                S_DEQ: begin
                    state_q   <= S_SETTLE;
                    deq_q     <= 1'b0;
                    deq_ack_q <= 1'b0;
                    last_op_q <= OP_DEQ;
                end
                S_SETTLE: begin
                    // FIFO flags update during this cycle.
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign enq      = enq_q;
    assign deq      = deq_q;
    assign ack      = ack_q;
    assign deq_ack  = deq_ack_q;
    assign enq_data = data_q;
    assign grant_id = grant_q;
    assign busy     = (state_q != S_IDLE);

endmodule : fifo_port_arbiter

// File: tb/tb_fifo_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_port_arbiter
// Bench for fifo_port_arbiter with N_REQ=2, WIDTH=4 against an 8-deep FIFO
// model whose full/empty flags update on the edge that performs enq/deq.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_fifo_port_arbiter;

    localparam int N_REQ = 2;
    localparam int WIDTH = 4;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] req = 2'b00;
    logic [7:0] din = 8'h00;
    logic       deq_req = 1'b0;
    logic [1:0] ack;
    logic       deq_ack;
    logic       fifo_full;
    logic       fifo_empty;
    logic       enq;
    logic       deq;
    logic [3:0] enq_data;
    logic [2:0] grant_id;
    logic       busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifo_port_arbiter #(
        .N_REQ (N_REQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .din        (din),
        .ack        (ack),
        .deq_req    (deq_req),
        .deq_ack    (deq_ack),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .enq        (enq),
        .deq        (deq),
        .enq_data   (enq_data),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    // ---------------- FIFO model ----------------
    logic       model_clr = 1'b1;
    int         model_fill = 0;
    logic [3:0] mem [DEPTH];
    logic [2:0] wr_ptr;
    logic [2:0] rd_ptr;
    int         count;
    int         cnt_nxt;
    logic       m_full;
    logic       m_empty;
    logic       ovf = 1'b0;
    logic       unf = 1'b0;
    logic [3:0] wr_log [$];
    logic [3:0] rd_log [$];
    int         enq_pulses = 0;

    logic       force_flags = 1'b0;
    logic       f_full = 1'b0;
    logic       f_empty = 1'b0;

    assign cnt_nxt    = count + int'(enq) - int'(deq);
    assign fifo_full  = force_flags ? f_full  : m_full;
    assign fifo_empty = force_flags ? f_empty : m_empty;

    always @(posedge clk) begin
        if (model_clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 4'(7 + i);
            rd_ptr  <= 3'd0;
            wr_ptr  <= 3'(model_fill);
            count   <= model_fill;
            m_full  <= (model_fill == DEPTH);
            m_empty <= (model_fill == 0);
        end else begin
            if (enq) begin
                if (count == DEPTH) ovf <= 1'b1;
                mem[wr_ptr] <= enq_data;
                wr_ptr      <= wr_ptr + 3'd1;
                wr_log.push_back(enq_data);
            end
            if (deq) begin
                if (count == 0) unf <= 1'b1;
                rd_ptr <= rd_ptr + 3'd1;
                rd_log.push_back(mem[rd_ptr]);
            end
            count   <= cnt_nxt;
            m_full  <= (cnt_nxt == DEPTH);
            m_empty <= (cnt_nxt == 0);
        end
    end

    always @(posedge enq) enq_pulses <= enq_pulses + 1;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Wait (bounded) for the next enq or deq strobe, sampled on falling edges.
    task automatic wait_op(input int max_cycles, output logic got_enq, output logic got_deq,
                           output int cycles);
        got_enq = 1'b0;
        got_deq = 1'b0;
        cycles  = max_cycles + 1;
        for (int c = 1; c <= max_cycles; c++) begin
            @(negedge clk);
            if (enq || deq) begin
                got_enq = enq;
                got_deq = deq;
                cycles  = c;
                break;
            end
        end
    endtask

    // Reset DUT and model together; model preloads 'fill' entries 7,8,9...
    task automatic do_reset(input int fill);
        rst        = 1'b0;
        model_clr  = 1'b1;
        model_fill = fill;
        repeat (2) @(negedge clk);
        model_clr = 1'b0;
        rst       = 1'b1;
    endtask

    typedef struct {
        logic [1:0] req;
        logic       exp_enq;
        logic [1:0] exp_ack;
        logic [3:0] exp_data;
        logic       exp_busy;
        logic [2:0] exp_grant;
    } vec_t;

    vec_t vecs [14];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ge, gd;
        int   cyc;
        int   base;
        int   p0;

        // Round-robin table: one row per cycle after reset release.
        vecs[0]  = '{2'b11, 1'b1, 2'b01, 4'hA, 1'b1, 3'd1};
        vecs[1]  = '{2'b11, 1'b0, 2'b00, 4'hA, 1'b1, 3'd0};
        vecs[2]  = '{2'b11, 1'b0, 2'b00, 4'hA, 1'b0, 3'd0};
        vecs[3]  = '{2'b11, 1'b1, 2'b10, 4'hB, 1'b1, 3'd0};
        vecs[4]  = '{2'b11, 1'b0, 2'b00, 4'hB, 1'b1, 3'd1};
        vecs[5]  = '{2'b11, 1'b0, 2'b00, 4'hB, 1'b0, 3'd1};
        vecs[6]  = '{2'b11, 1'b1, 2'b01, 4'hA, 1'b1, 3'd1};
        vecs[7]  = '{2'b11, 1'b0, 2'b00, 4'hA, 1'b1, 3'd0};
        vecs[8]  = '{2'b11, 1'b0, 2'b00, 4'hA, 1'b0, 3'd0};
        vecs[9]  = '{2'b11, 1'b1, 2'b10, 4'hB, 1'b1, 3'd0};
        vecs[10] = '{2'b00, 1'b0, 2'b00, 4'hB, 1'b1, 3'd1};
        vecs[11] = '{2'b00, 1'b0, 2'b00, 4'hB, 1'b0, 3'd1};
        vecs[12] = '{2'b00, 1'b0, 2'b00, 4'hB, 1'b0, 3'd1};
        vecs[13] = '{2'b00, 1'b0, 2'b00, 4'hB, 1'b0, 3'd1};

        // 1: reset state with requests pending
        req = 2'b11;
        din = 8'hBA;
        repeat (2) @(negedge clk);
        check("rst_enq", enq, 1'b0);
        check("rst_deq", deq, 1'b0);
        check("rst_ack", ack, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_grant", grant_id, 3'd1);
        check("rst_data", enq_data, 4'h0);
        model_clr = 1'b0;
        rst       = 1'b1;

        // 2: round robin A,B,A,B, one enq every 3 cycles
        for (int i = 0; i < 14; i++) begin
            req = vecs[i].req;
            @(negedge clk);
            check($sformatf("rr[%0d].enq", i), enq, vecs[i].exp_enq);
            check($sformatf("rr[%0d].ack", i), ack, vecs[i].exp_ack);
            check($sformatf("rr[%0d].data", i), enq_data, vecs[i].exp_data);
            check($sformatf("rr[%0d].busy", i), busy, vecs[i].exp_busy);
            check($sformatf("rr[%0d].grant", i), grant_id, vecs[i].exp_grant);
        end
        check("rr_writes", wr_log.size(), 4);
        if (wr_log.size() == 4) begin
            check("rr_w0", wr_log[0], 4'hA);
            check("rr_w1", wr_log[1], 4'hB);
            check("rr_w2", wr_log[2], 4'hA);
            check("rr_w3", wr_log[3], 4'hB);
        end

        // 3: fill to 8 with producer 0, then a 9th request while full
        req = 2'b01;
        for (int w = 0; w < 4; w++) begin
            din[3:0] = 4'(w + 1);
            wait_op(10, ge, gd, cyc);
            check($sformatf("fill[%0d].enq", w), ge, 1'b1);
            check($sformatf("fill[%0d].ack", w), ack, 2'b01);
            check($sformatf("fill[%0d].data", w), enq_data, 4'(w + 1));
        end
        din[3:0] = 4'h9;
        wait_op(10, ge, gd, cyc);
        check("full_no_enq", ge, 1'b0);
        check("full_flag", fifo_full, 1'b1);
        check("full_no_ack", ack, 2'b00);
        base = rd_log.size();
        deq_req = 1'b1;
        wait_op(5, ge, gd, cyc);
        check("full_deq", gd, 1'b1);
        check("full_deq_ack", deq_ack, 1'b1);
        check("full_deq_lat", cyc, 1);
        deq_req = 1'b0;
        wait_op(10, ge, gd, cyc);
        check("full_pending_enq", ge, 1'b1);
        check("full_pending_lat", cyc, 3);
        check("full_pending_data", enq_data, 4'h9);
        req = 2'b00;
        repeat (3) @(negedge clk);
        check("full_read_cnt", rd_log.size() - base, 1);
        if (rd_log.size() > base) check("full_read_val", rd_log[base], 4'hA);
        check("full_total_writes", wr_log.size(), 9);

        // 4: dequeue on empty FIFO, then enqueue 5 and read it back
        do_reset(0);
        deq_req = 1'b1;
        wait_op(10, ge, gd, cyc);
        check("empty_no_deq", gd, 1'b0);
        check("empty_busy", busy, 1'b0);
        base = rd_log.size();
        din[3:0] = 4'h5;
        req = 2'b01;
        wait_op(5, ge, gd, cyc);
        check("empty_enq", ge, 1'b1);
        req = 2'b00;
        wait_op(10, ge, gd, cyc);
        check("empty_then_deq", gd, 1'b1);
        check("empty_deq_lat", cyc, 3);
        deq_req = 1'b0;
        @(negedge clk);
        check("empty_read_cnt", rd_log.size() - base, 1);
        if (rd_log.size() > base) check("empty_read_val", rd_log[base], 4'h5);

        // Illegal full&empty: nothing issued, FSM stays idle
        force_flags = 1'b1;
        f_full      = 1'b1;
        f_empty     = 1'b1;
        req         = 2'b11;
        deq_req     = 1'b1;
        do_reset(0);
        wait_op(8, ge, gd, cyc);
        check("illegal_no_enq", ge, 1'b0);
        check("illegal_no_deq", gd, 1'b0);
        check("illegal_busy", busy, 1'b0);
        req         = 2'b00;
        deq_req     = 1'b0;
        force_flags = 1'b0;

        // 5: tie alternation with 3 entries preloaded (7,8,9)
        req      = 2'b01;
        din[3:0] = 4'h6;
        deq_req  = 1'b1;
        do_reset(3);
        base = rd_log.size();
        for (int k = 0; k < 4; k++) begin
            wait_op(10, ge, gd, cyc);
            check($sformatf("tie[%0d].op", k), {ge, gd}, (k % 2 == 0) ? 2'b10 : 2'b01);
            check($sformatf("tie[%0d].lat", k), cyc, (k == 0) ? 1 : 3);
        end
        req     = 2'b00;
        deq_req = 1'b0;
        repeat (2) @(negedge clk);
        check("tie_read_cnt", rd_log.size() - base, 2);
        if (rd_log.size() - base == 2) begin
            check("tie_read0", rd_log[base], 4'h7);
            check("tie_read1", rd_log[base + 1], 4'h8);
        end

        // 6: async reset in the middle of ENQ
        do_reset(0);
        p0       = enq_pulses;
        din[3:0] = 4'hC;
        req      = 2'b01;
        wait_op(5, ge, gd, cyc);
        check("areset_enq_seen", ge, 1'b1);
        #2;
        rst = 1'b0;
        req = 2'b00;
        #1;
        check("areset_enq_low", enq, 1'b0);
        check("areset_ack_low", ack, 2'b00);
        check("areset_busy_low", busy, 1'b0);
        check("areset_grant", grant_id, 3'd1);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("areset_idle", busy, 1'b0);
        check("areset_one_strobe", enq_pulses - p0, 1);

        check("model_overflow", ovf, 1'b0);
        check("model_underflow", unf, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fifo_port_arbiter
